// File: rtl/an_barrett_decoder_pipe_pkg.sv
// Shared AN-code constants and elaboration-time helpers for Barrett decoding.
package an_pkg;

    localparam int AN_A    = 13;
    localparam int AN_CW_W = 16;

    // Width used for elaboration-time arithmetic; wide enough for 2**K with K up to 2*CW_W.
    localparam int AN_WIDE = 128;

    // Barrett constant floor(2**k / a).
    function automatic logic [AN_WIDE-1:0] barrett_m(input int a, input int k);
        logic [AN_WIDE-1:0] one;
        logic [AN_WIDE-1:0] div;
        one = AN_WIDE'(1);
        div = AN_WIDE'(a);
        return (one << k) / div;
    endfunction

    // Bits needed to hold the largest quotient (2**cw_w - 1) / a exactly.
    function automatic int an_q_width(input int cw_w, input int a);
        logic [AN_WIDE-1:0] max_q;
        max_q = ((AN_WIDE'(1) << cw_w) - AN_WIDE'(1)) / AN_WIDE'(a);
        return $clog2(max_q + AN_WIDE'(1));
    endfunction

    // Bits needed to hold a residue in [0, a-1].
    function automatic int an_r_width(input int a);
        return $clog2(a);
    endfunction

endpackage

// File: rtl/an_barrett_decoder_pipe_if.sv
// Codeword-in / decoded-result-out stream bundle for the AN decoder.
interface an_barrett_decoder_pipe_if
    import an_pkg::*;
#(
    parameter int CW_W = AN_CW_W,
    parameter int A    = AN_A
);

    localparam int Q_W = an_q_width(CW_W, A);
    localparam int R_W = an_r_width(A);

    logic            in_valid;
    logic            in_ready;
    logic [CW_W-1:0] in_codeword;
    logic            out_valid;
    logic            out_ready;
    logic [Q_W-1:0]  out_q;
    logic [R_W-1:0]  out_r;
    logic            out_error;

    // Source of codewords and sink of results.
    modport master (
        output in_valid,
        output in_codeword,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_q,
        input  out_r,
        input  out_error
    );

    // The decoder itself.
    modport slave (
        input  in_valid,
        input  in_codeword,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_q,
        output out_r,
        output out_error
    );

endinterface

// File: rtl/an_barrett_decoder_pipe_correct.sv
// Final Barrett correction: one conditional subtract of A plus the error flag.
module an_barrett_correct #(
    parameter int CW_W = 16,
    parameter int A    = 13,
    parameter int Q_W  = 13,
    parameter int R_W  = 4
) (
    input  logic [Q_W-1:0]  q_est,
    input  logic [CW_W:0]   r_est,
    output logic [Q_W-1:0]  q,
    output logic [R_W-1:0]  r,
    output logic            error
);

    localparam logic [CW_W:0] A_EXT = (CW_W + 1)'(A);

    logic          take;
    logic [CW_W:0] r_sel;

    // r_est == A must also subtract; the flag looks at the full-width residue.
    always_comb begin
        take  = (r_est >= A_EXT);
        q     = take ? (q_est + Q_W'(1)) : q_est;
        r_sel = take ? (r_est - A_EXT) : r_est;
        r     = r_sel[R_W-1:0];
        error = (r_sel != '0);
    end

endmodule

// File: rtl/an_barrett_decoder_pipe.sv
// Three-stage Barrett AN-code decoder with global-stall handshake and saturating error counter.
module an_barrett_decoder_pipe
    import an_pkg::*;
#(
    parameter int CW_W  = AN_CW_W,
    parameter int A     = AN_A,
    parameter int K     = 2 * CW_W,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    an_barrett_decoder_pipe_if.slave bus,
    input  logic                    clr_count,
    output logic [CNT_W-1:0]        err_count
);

    localparam logic [AN_WIDE-1:0] M_FULL = barrett_m(A, K);
    localparam logic [K-1:0]       M      = M_FULL[K-1:0];
    localparam int                 P_W    = CW_W + K;
    localparam int                 Q_W    = an_q_width(CW_W, A);
    localparam int                 R_W    = an_r_width(A);
    localparam logic [CW_W:0]      A_EXT  = (CW_W + 1)'(A);

    logic            en;

    logic            s1_valid_q, s1_valid_d;
    logic [CW_W-1:0] s1_cw_q,    s1_cw_d;
    logic [P_W-1:0]  s1_p_q,     s1_p_d;

    logic            s2_valid_q, s2_valid_d;
    logic [Q_W-1:0]  s2_q_est_q, s2_q_est_d;
    logic [CW_W:0]   s2_r_est_q, s2_r_est_d;

    logic            out_valid_q, out_valid_d;
    logic [Q_W-1:0]  out_q_q,     out_q_d;
    logic [R_W-1:0]  out_r_q,     out_r_d;
    logic            out_error_q, out_error_d;

    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic [P_W-1:0]  product;
    logic [CW_W-1:0] q_est_full;
    logic [CW_W:0]   q_times_a;
    logic [CW_W:0]   r_est;
    logic [Q_W-1:0]  corr_q;
    logic [R_W-1:0]  corr_r;
    logic            corr_err;

    // Low product bits are below the Barrett shift, and q_est never reaches the top CW_W-Q_W bits.
    logic            unused_bits;

    assign en = !out_valid_q || bus.out_ready;

    assign product    = {{K{1'b0}}, bus.in_codeword} * {{CW_W{1'b0}}, M};
    assign q_est_full = s1_p_q[P_W-1:K];
    assign q_times_a  = {1'b0, q_est_full} * A_EXT;
    assign r_est      = {1'b0, s1_cw_q} - q_times_a;
    assign unused_bits = ^{s1_p_q[K-1:0], q_est_full[CW_W-1:Q_W]};

    an_barrett_correct #(
        .CW_W (CW_W),
        .A    (A),
        .Q_W  (Q_W),
        .R_W  (R_W)
    ) u_correct (
        .q_est (s2_q_est_q),
        .r_est (s2_r_est_q),
        .q     (corr_q),
        .r     (corr_r),
        .error (corr_err)
    );

    // Whole pipeline, valid bits included, advances together or holds together.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_cw_d     = s1_cw_q;
        s1_p_d      = s1_p_q;
        s2_valid_d  = s2_valid_q;
        s2_q_est_d  = s2_q_est_q;
        s2_r_est_d  = s2_r_est_q;
        out_valid_d = out_valid_q;
        out_q_d     = out_q_q;
        out_r_d     = out_r_q;
        out_error_d = out_error_q;
        if (en) begin
            s1_valid_d  = bus.in_valid;
            s1_cw_d     = bus.in_codeword;
            s1_p_d      = product;
            s2_valid_d  = s1_valid_q;
            s2_q_est_d  = q_est_full[Q_W-1:0];
            s2_r_est_d  = r_est;
            out_valid_d = s2_valid_q;
            out_q_d     = corr_q;
            out_r_d     = corr_r;
            out_error_d = corr_err;
        end
    end

    // Count delivered error results; clear beats a simultaneous increment, no wrap at full scale.
    always_comb begin
        err_count_d = err_count_q;
        if (clr_count) begin
            err_count_d = '0;
        end else if (out_valid_q && bus.out_ready && out_error_q && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_cw_q     <= '0;
            s1_p_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_q_est_q  <= '0;
            s2_r_est_q  <= '0;
            out_valid_q <= 1'b0;
            out_q_q     <= '0;
            out_r_q     <= '0;
            out_error_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_cw_q     <= s1_cw_d;
            s1_p_q      <= s1_p_d;
            s2_valid_q  <= s2_valid_d;
            s2_q_est_q  <= s2_q_est_d;
            s2_r_est_q  <= s2_r_est_d;
            out_valid_q <= out_valid_d;
            out_q_q     <= out_q_d;
            out_r_q     <= out_r_d;
            out_error_q <= out_error_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_q     = out_q_q;
    assign bus.out_r     = out_r_q;
    assign bus.out_error = out_error_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_an_barrett_decoder_pipe.sv
// Self-checking bench: three decoder instances (A=13/16b, A=13/16b with 4-bit counter, A=7/8b).
module tb_an_barrett_decoder_pipe;

    logic clk;
    logic rst_n;

    logic        clr0, clr1, clr2;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;
    logic [15:0] cnt2;

    int checks;
    int errors;
    int model_errs0;

    an_barrett_decoder_pipe_if #(.CW_W(16), .A(13)) b0 ();
    an_barrett_decoder_pipe_if #(.CW_W(16), .A(13)) b1 ();
    an_barrett_decoder_pipe_if #(.CW_W(8),  .A(7))  b2 ();

    an_barrett_decoder_pipe #(.CW_W(16), .A(13), .K(32), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave), .clr_count(clr0), .err_count(cnt0));
    an_barrett_decoder_pipe #(.CW_W(16), .A(13), .K(32), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave), .clr_count(clr1), .err_count(cnt1));
    an_barrett_decoder_pipe #(.CW_W(8), .A(7), .K(16), .CNT_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave), .clr_count(clr2), .err_count(cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        b0.in_valid = 1'b1;
        b0.in_codeword = 16'd1300;
        b0.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (b0.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hold out_valid: got %0b want 0", b0.out_valid);
        end
        rst_n = 1'b1;
        b0.in_valid = 1'b0;
        #1;
        checks++;
        if (b0.out_valid !== 1'b0 || cnt0 !== 16'd0 || b0.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got valid=%0b cnt=%0d in_ready=%0b want 0 0 1",
                     b0.out_valid, cnt0, b0.in_ready);
        end
        checks++;
        if (b1.out_valid !== 1'b0 || cnt1 !== 4'd0 || b2.out_valid !== 1'b0 || cnt2 !== 16'd0) begin
            errors++; $display("FAIL reset_other_duts: got v1=%0b c1=%0d v2=%0b c2=%0d want 0",
                               b1.out_valid, cnt1, b2.out_valid, cnt2);
        end
        // Reset while two items are in flight: neither may surface afterwards.
        @(posedge clk); #1;
        b0.in_valid = 1'b1; b0.in_codeword = 16'd100;
        @(posedge clk); #1;
        b0.in_codeword = 16'd200;
        @(posedge clk); #1;
        b0.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (b0.out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_flush cycle %0d: got out_valid=%0b want 0", i, b0.out_valid);
            end
        end
    endtask

    task automatic test_single();
        int xs [5] = '{1300, 1301, 12, 0, 65535};
        int qs [5] = '{100, 100, 0, 0, 5041};
        int rs [5] = '{0, 1, 12, 0, 2};
        int n;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            b0.in_valid = 1'b1;
            b0.in_codeword = 16'(xs[k]);
            b0.out_ready = 1'b1;
            n = 0;
            do begin
                @(posedge clk); #1;
                b0.in_valid = 1'b0;
                n++;
            end while (b0.out_valid !== 1'b1 && n < 10);
            checks++;
            if (n != 3) begin
                errors++; $display("FAIL single_latency x=%0d: got %0d cycles want 3", xs[k], n);
            end
            checks++;
            if (b0.out_q !== 13'(qs[k]) || b0.out_r !== 4'(rs[k]) || b0.out_error !== (rs[k] != 0)) begin
                errors++;
                $display("FAIL single x=%0d: got q=%0d r=%0d e=%0b want q=%0d r=%0d e=%0b",
                         xs[k], b0.out_q, b0.out_r, b0.out_error, qs[k], rs[k], rs[k] != 0);
            end
            if (rs[k] != 0) model_errs0++;
        end
        @(posedge clk); #1;
        checks++;
        if (cnt0 !== 16'(model_errs0)) begin
            errors++; $display("FAIL single_err_count: got %0d want %0d", cnt0, model_errs0);
        end
    endtask

    task automatic test_clear0();
        @(posedge clk); #1;
        clr0 = 1'b1;
        @(posedge clk); #1;
        clr0 = 1'b0;
        model_errs0 = 0;
        checks++;
        if (cnt0 !== 16'd0) begin
            errors++; $display("FAIL clear0: got %0d want 0", cnt0);
        end
    endtask

    // Streams n codewords through dut0 with random valid/ready, checking order, values and stall stability.
    task automatic stream0(input int n, input bit rnd, input int rdy_pct, input int vld_pct, input string tag);
        int expq [$];
        int expr [$];
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int x, eq, er;
        bit stall_prev = 1'b0;
        logic [12:0] hq;
        logic [3:0]  hr;
        logic        he;
        while (got < n && cyc < n * 20 + 100) begin
            @(posedge clk); #1;
            cyc++;
            if (stall_prev) begin
                checks++;
                if (b0.out_valid !== 1'b1 || b0.out_q !== hq || b0.out_r !== hr || b0.out_error !== he) begin
                    errors++;
                    $display("FAIL %s stall_hold: got v=%0b q=%0d r=%0d e=%0b want v=1 q=%0d r=%0d e=%0b",
                             tag, b0.out_valid, b0.out_q, b0.out_r, b0.out_error, hq, hr, he);
                end
            end
            b0.out_ready = ($urandom_range(0, 99) < rdy_pct);
            if (sent < n && $urandom_range(0, 99) < vld_pct) begin
                x = rnd ? int'($urandom_range(0, 65535)) : sent;
                b0.in_valid = 1'b1;
                b0.in_codeword = 16'(x);
            end else begin
                b0.in_valid = 1'b0;
            end
            #1;
            checks++;
            if (b0.in_ready !== (!b0.out_valid || b0.out_ready)) begin
                errors++; $display("FAIL %s in_ready: got %0b want %0b", tag, b0.in_ready,
                                   !b0.out_valid || b0.out_ready);
            end
            if (b0.out_valid === 1'b1 && b0.out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL %s spurious result: got q=%0d want none", tag, b0.out_q);
                end else begin
                    eq = expq.pop_front();
                    er = expr.pop_front();
                    if (b0.out_q !== 13'(eq) || b0.out_r !== 4'(er) || b0.out_error !== (er != 0)) begin
                        errors++;
                        $display("FAIL %s item %0d: got q=%0d r=%0d e=%0b want q=%0d r=%0d e=%0b",
                                 tag, got, b0.out_q, b0.out_r, b0.out_error, eq, er, er != 0);
                    end
                    if (er != 0) model_errs0++;
                end
                got++;
            end
            if (b0.in_valid && b0.in_ready === 1'b1) begin
                x = int'(b0.in_codeword);
                expq.push_back(x / 13);
                expr.push_back(x % 13);
                sent++;
            end
            stall_prev = (b0.out_valid === 1'b1) && !b0.out_ready;
            hq = b0.out_q; hr = b0.out_r; he = b0.out_error;
        end
        b0.in_valid = 1'b0;
        b0.out_ready = 1'b1;
        checks++;
        if (got != n) begin
            errors++; $display("FAIL %s count: got %0d results want %0d", tag, got, n);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (b0.out_valid !== 1'b0) begin
                errors++; $display("FAIL %s extra result: got out_valid=%0b want 0", tag, b0.out_valid);
            end
        end
        checks++;
        if (cnt0 !== 16'((model_errs0 > 65535) ? 65535 : model_errs0)) begin
            errors++; $display("FAIL %s err_count: got %0d want %0d", tag, cnt0, model_errs0);
        end
    endtask

    task automatic test_sweep();
        stream0(65536, 1'b0, 100, 100, "sweep");
        checks++;
        if (cnt0 !== 16'd60494) begin
            errors++; $display("FAIL sweep_err_total: got %0d want 60494", cnt0);
        end
    endtask

    task automatic test_backpressure();
        stream0(100, 1'b0, 50, 100, "backpressure");
    endtask

    task automatic test_random();
        stream0(2000, 1'b1, 70, 80, "random");
    endtask

    task automatic feed1(input int n);
        int x;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            do x = int'($urandom_range(0, 65535)); while (x % 13 == 0);
            b1.in_valid = 1'b1;
            b1.in_codeword = 16'(x);
            b1.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_counter();
        int n;
        feed1(10);
        checks++;
        if (cnt1 !== 4'd10) begin
            errors++; $display("FAIL counter_10: got %0d want 10", cnt1);
        end
        feed1(10);
        checks++;
        if (cnt1 !== 4'd15) begin
            errors++; $display("FAIL counter_saturate: got %0d want 15", cnt1);
        end
        @(posedge clk); #1;
        b1.in_valid = 1'b1;
        b1.in_codeword = 16'd1;
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
        n = 0;
        while (b1.out_valid !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        clr1 = 1'b1;
        checks++;
        if (b1.out_valid !== 1'b1 || b1.out_error !== 1'b1) begin
            errors++; $display("FAIL clear_collision_setup: got v=%0b e=%0b want 1 1", b1.out_valid, b1.out_error);
        end
        @(posedge clk); #1;
        clr1 = 1'b0;
        checks++;
        if (cnt1 !== 4'd0 || b1.out_valid !== 1'b0) begin
            errors++; $display("FAIL clear_collision: got cnt=%0d v=%0b want 0 0", cnt1, b1.out_valid);
        end
        feed1(1);
        checks++;
        if (cnt1 !== 4'd1) begin
            errors++; $display("FAIL counter_after_clear: got %0d want 1", cnt1);
        end
    endtask

    task automatic test_reparam();
        int expq [$];
        int expr [$];
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int x, eq, er;
        int nerr = 0;
        b2.out_ready = 1'b1;
        while (got < 256 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (sent < 256) begin
                b2.in_valid = 1'b1;
                b2.in_codeword = 8'(sent);
            end else begin
                b2.in_valid = 1'b0;
            end
            #1;
            if (b2.out_valid === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL reparam spurious: got q=%0d want none", b2.out_q);
                end else begin
                    eq = expq.pop_front();
                    er = expr.pop_front();
                    if (b2.out_q !== 6'(eq) || b2.out_r !== 3'(er) || b2.out_error !== (er != 0)) begin
                        errors++;
                        $display("FAIL reparam item %0d: got q=%0d r=%0d e=%0b want q=%0d r=%0d e=%0b",
                                 got, b2.out_q, b2.out_r, b2.out_error, eq, er, er != 0);
                    end
                    if (er != 0) nerr++;
                end
                got++;
            end
            if (b2.in_valid && b2.in_ready === 1'b1) begin
                x = int'(b2.in_codeword);
                expq.push_back(x / 7);
                expr.push_back(x % 7);
                sent++;
            end
        end
        b2.in_valid = 1'b0;
        checks++;
        if (got != 256) begin
            errors++; $display("FAIL reparam count: got %0d want 256", got);
        end
        @(posedge clk); #1;
        checks++;
        if (cnt2 !== 16'(nerr) || cnt2 !== 16'd219) begin
            errors++; $display("FAIL reparam err_count: got %0d want %0d", cnt2, nerr);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_errs0 = 0;
        rst_n = 1'b0;
        clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
        b0.in_valid = 1'b0; b0.in_codeword = '0; b0.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.in_codeword = '0; b1.out_ready = 1'b1;
        b2.in_valid = 1'b0; b2.in_codeword = '0; b2.out_ready = 1'b1;
        test_reset();
        test_single();
        test_clear0();
        test_sweep();
        test_backpressure();
        test_random();
        test_counter();
        test_reparam();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/an_barrett_decoder_pipe.md
Name: an_barrett_decoder_pipe

Overview:
- Parametrised, pipelined AN-code decoder. Each incoming codeword is split as codeword = q*A + r using Barrett reduction (multiply by a precomputed constant, shift, then at most one correction step).
- Outputs the decoded data q, the residue r and an error flag (r != 0).
- Carries a valid/ready handshake with backpressure and keeps a saturating error counter.
- Sits between the channel-side codeword source and the data sink in the AN-decoder datapath. It replaces the fixed A=13, 6-bit combinational reducer.

Parameters:
- CW_W, 16, codeword width in bits (>= 4).
- A, 13, AN-code multiplier; odd, 3 <= A < 2**(CW_W-1).
- K, 2*CW_W, Barrett shift amount; must satisfy 2**K >= (2**CW_W)*A so that one correction step always suffices.
- CNT_W, 16, error counter width.
- Derived localparams (not overridable):
  - M = floor(2**K / A)
  - R_W = $clog2(A)
  - Q_W = $clog2((2**CW_W - 1)/A + 1)

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  in_codeword is valid.
- in_ready  out  1  block accepts in_codeword this cycle.
- in_codeword  in  CW_W  received codeword, unsigned.
- out_valid  out  1  result is valid.
- out_ready  in  1  sink accepts the result.
- out_q  out  Q_W  quotient, i.e. the decoded data word.
- out_r  out  R_W  residue, 0 <= out_r < A.
- out_error  out  1  1 when out_r != 0.
- clr_count  in  1  synchronous clear of err_count.
- err_count  out  CNT_W  saturating count of delivered results with out_error = 1.

Behaviour:
- Reset (rst_n = 0 at a clk edge): all stage valid bits = 0, out_valid = 0, out_q = 0, out_r = 0, out_error = 0, err_count = 0. A reset applied mid-operation discards every in-flight item; nothing is emitted after reset releases.
- Pipeline, 3 register stages, latency 3 cycles from input handshake to out_valid when there is no stall:
  - S1: p = in_codeword * M, full CW_W+K-bit unsigned product, registered together with in_codeword.
  - S2: q_est = p >> K; r_est = codeword - q_est*A, computed at CW_W+1 bits (r_est is in [0, 2A-1]).
  - S3: if r_est >= A then q = q_est+1 and r = r_est-A; else q = q_est and r = r_est. error = (r != 0). Registered onto out_*.
- Handshake:
  - Single global advance enable: en = !out_valid || out_ready. in_ready = en.
  - All stages, valid bits included, shift only when en = 1.
  - Bubbles propagate as valid = 0.
  - When en = 0, every stage and every out_* signal holds its value (outputs stable while out_valid && !out_ready).
  - Input is accepted on in_valid && in_ready. Full throughput is 1 item/cycle.
  - Ordering is strictly FIFO; no reordering, no drop.
- Arithmetic: all values unsigned; no truncation before the S3 compare. Q_W holds the maximum quotient exactly.
- Error counter:
  - Increments on out_valid && out_ready && out_error.
  - Saturates at 2**CNT_W-1 (no wrap).
  - clr_count = 1 sets it to 0. If clr_count and an increment event occur in the same cycle, clear wins and that event is not counted.
- Boundary cases:
  - codeword = 0 gives q = 0, r = 0.
  - codeword = 2**CW_W-1 must produce the exact quotient.
  - r_est = A exactly takes the correction branch.
  - A back-to-back stream under intermittent out_ready must lose or duplicate no items.

Decomposition:
- Package an_pkg holds:
  - function barrett_m(a, k) returning floor(2**k/a)
  - functions for the derived widths Q_W and R_W
  - default constants AN_A = 13 and AN_CW_W = 16, shared with the future encoder.
- One sub-module, an_barrett_correct (combinational S3 correction and error flag). It is reused by a planned runtime-A variant.
- Pipeline registers, handshake and counter stay in the top module.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 -> out_valid = 0, err_count = 0, in_ready = 1 after release.
- Single items (A=13, CW_W=16), each with out_ready = 1:
  - 1300 -> q = 100, r = 0, err = 0
  - 1301 -> q = 100, r = 1, err = 1
  - 12 -> q = 0, r = 12, err = 1
  - 0 -> q = 0, r = 0, err = 0
  - 65535 -> q = 5041, r = 2, err = 1
  - Each result appears exactly 3 cycles after acceptance.
- Exhaustive sweep 0..65535 at full rate with out_ready = 1 -> every result matches q = x/13, r = x%13 in order. err_count = 60494 (65536 - 5042 multiples of 13; no saturation at CNT_W = 16).
- Backpressure: stream 0..99 with out_ready toggling pseudo-randomly -> exactly 100 results, in order, outputs stable while stalled, in_ready low only when out_valid && !out_ready.
- Counter: CNT_W = 4, feed 20 non-multiples -> err_count saturates at 15. Then assert clr_count in the same cycle as an error result -> err_count = 0.
- Reparametrise A = 7, CW_W = 8: sweep 0..255 -> matches x/7 and x%7. Includes 255 -> q = 36, r = 3.
